predecode_branch: RTL and testbench
===================================

PREDECODE_BRANCH -- requirements
Module: predecode_branch

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port ready  input  1  cycle enable; when low, all registers hold.
REQ-004 SHALL have port t  input  3  current T-state from the timing sequencer; T1=3'b001 marks opcode fetch, T2=3'b010 marks first operand fetch.
REQ-005 SHALL have port data_in  input  8  read-data bus: opcode in T1, operand byte in T2.
REQ-006 SHALL have port flags  input  4  {N,V,Z,C} processor status bits.
REQ-007 SHALL have port pcl  input  8  low byte of PC after the operand fetch.
REQ-008 SHALL have port ir  output  8  latched opcode.
REQ-009 SHALL have port onecycle  output  1  the latched opcode completes in one cycle.
REQ-010 SHALL have port twocycle  output  1  the latched opcode completes in two cycles.
REQ-011 SHALL have port taken_branch  output  1  branch condition is true.
REQ-012 SHALL have port branch_page_cross  output  1  branch target lies in a different page.

Function
REQ-013 SHALL, on ready=1 and t=T1, latch data_in into ir and register the classification outputs; these outputs are valid from the next cycle until the next T1 capture.
REQ-014 SHALL assert onecycle iff opcode[3:0] is 4'h3 or 4'hB.
REQ-015 SHALL assert twocycle for: low nibble 4'h8 excluding 08/28/48/68; low nibble 4'hA with high nibble 8..F, plus 0A/2A/4A/6A; immediates 09/29/49/69/A9/C9/E9/A0/A2/C0/E0.
REQ-016 SHALL classify opcode as a branch iff opcode[4:0]=5'b10000; the condition is opcode[7:6] (0=N, 1=V, 2=C, 3=Z) and the sense is opcode[5].
REQ-017 SHALL implement the FSM IDLE -> BR_EVAL -> BR_ADD -> IDLE; a branch captured in T1 enters BR_EVAL, and a non-branch stays in IDLE.
REQ-018 SHALL, in BR_EVAL at ready=1 and t=T2, latch the offset from data_in and register taken_branch = (selected flag == sense); go to BR_ADD if taken, otherwise go to IDLE.
REQ-019 SHALL, in BR_ADD at ready=1, compute the 9-bit sum pcl + sign-extended offset; branch_page_cross = 1 if the sum carries out with a positive offset, or lacks the borrow-carry with a negative offset; then go to IDLE.
REQ-020 SHALL clear taken_branch and branch_page_cross on every T1 capture.
REQ-021 SHALL treat a T1 capture in any state as aborting the current state and restarting classification (new opcode takes priority).
REQ-022 SHALL, when ready=0, hold the state, ir and all outputs unchanged regardless of t.
REQ-023 SHALL produce outputs that are all registered, with no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, on reset assertion, set state=IDLE, ir=8'h00, and all other outputs and internal registers to 0, independent of clk.
REQ-025 SHALL resume at the first T1 capture after reset deassertion.

Configuration
REQ-026 SHALL, when CMOS_BRA_EN is defined, treat opcode 8'h80 as an always-taken branch (taken_branch=1 in BR_EVAL, proceeding to BR_ADD).
REQ-027 SHALL, when CMOS_BRA_EN is undefined, classify 8'h80 as a twocycle non-branch.

Structure
REQ-028 SHALL place the T-state encodings (T0..T7), the FSM state encodings and the flag index constants in the shared 65xx package or include file.
REQ-029 SHALL implement the opcode classifier (REQ-014..REQ-016, REQ-026/027) as one combinational sub-module, opcode_class.

Verification
REQ-030 SHALL cover: T1 with data_in=8'hEA -> next cycle ir=EA, twocycle=1, onecycle=0, state IDLE.
REQ-031 SHALL cover: BEQ (8'hF0) with Z=1, T2 offset=8'h10, pcl=8'hF8 -> taken_branch=1, then branch_page_cross=1 (F8+10 carries).
REQ-032 SHALL cover: BNE (8'hD0) with Z=1 -> taken_branch=0, FSM returns to IDLE after T2, branch_page_cross stays 0.
REQ-033 SHALL cover: BPL (8'h10) with N=0, offset=8'hFE, pcl=8'h05 -> taken=1, page_cross=0; with pcl=8'h01 -> page_cross=1.
REQ-034 SHALL cover: ready held low for 3 cycles during BR_ADD -> outputs and state frozen, and the addition completes on the first ready=1 cycle.
REQ-035 SHALL cover: reset asserted mid-BR_EVAL -> all outputs 0 immediately; 8'h80 yields taken=1 with CMOS_BRA_EN and twocycle=1 without it.

Source files
------------

// File: rtl/predecode_branch_pkg.sv
// Shared 65xx constants: T-state encodings, predecode FSM states and
// status-flag bit positions within the {N,V,Z,C} flags bus.
package predecode_branch_pkg;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BR_EVAL = 2'd1,
    BR_ADD  = 2'd2
  } state_t;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  // Branch condition selector as encoded in opcode[7:6].
  localparam logic [1:0] COND_N = 2'd0;
  localparam logic [1:0] COND_V = 2'd1;
  localparam logic [1:0] COND_C = 2'd2;
  localparam logic [1:0] COND_Z = 2'd3;

endpackage

// File: rtl/predecode_branch_opcode_class.sv
// Combinational 65xx opcode classifier: cycle-count hints and branch decode.
// CMOS_BRA_EN: opcode 8'h80 decodes as an always-taken branch (BRA).
module opcode_class
  import predecode_branch_pkg::*;
(
  input  logic [7:0] op,
  output logic       onecycle,
  output logic       twocycle,
  output logic       is_branch,
  output logic       always_taken,
  output logic [1:0] cond_sel,
  output logic       sense
);

  logic [3:0] lo;
  logic [3:0] hi;

  assign lo = op[3:0];
  assign hi = op[7:4];

  always_comb begin
    onecycle     = (lo == 4'h3) || (lo == 4'hB);
    twocycle     = 1'b0;
    is_branch    = (op[4:0] == 5'b10000);
    always_taken = 1'b0;
    cond_sel     = op[7:6];
    sense        = op[5];

    if (lo == 4'h8)
      twocycle = !((op == 8'h08) || (op == 8'h28) || (op == 8'h48) || (op == 8'h68));
    else if (lo == 4'hA)
      twocycle = (hi >= 4'h8) || (op == 8'h0A) || (op == 8'h2A) ||
                 (op == 8'h4A) || (op == 8'h6A);

    case (op)
      8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9,
      8'hA0, 8'hA2, 8'hC0, 8'hE0: twocycle = 1'b1;
      default: ;
    endcase

`ifdef CMOS_BRA_EN
    if (op == 8'h80) begin
      is_branch    = 1'b1;
      always_taken = 1'b1;
    end
`else
    if (op == 8'h80)
      twocycle = 1'b1;
`endif
  end

endmodule

// File: rtl/predecode_branch.sv
// Opcode predecode plus conditional-branch evaluation and page-cross detection.
// Build option CMOS_BRA_EN (see opcode_class) enables the 8'h80 BRA opcode.
module predecode_branch
  import predecode_branch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic [2:0] t,
  input  logic [7:0] data_in,
  input  logic [3:0] flags,
  input  logic [7:0] pcl,
  output logic [7:0] ir,
  output logic       onecycle,
  output logic       twocycle,
  output logic       taken_branch,
  output logic       branch_page_cross
);

  state_t     state, state_n;
  logic [7:0] ir_n;
  logic       onecycle_n, twocycle_n, taken_n, cross_n;
  logic [7:0] offset, offset_n;
  logic [1:0] cond, cond_n;
  logic       sense, sense_n;
  logic       always_br, always_br_n;

  logic       c_one, c_two, c_branch, c_always, c_sense;
  logic [1:0] c_cond;
  logic       flag_sel;
  logic [8:0] sum;

  opcode_class u_class (
    .op           (data_in),
    .onecycle     (c_one),
    .twocycle     (c_two),
    .is_branch    (c_branch),
    .always_taken (c_always),
    .cond_sel     (c_cond),
    .sense        (c_sense)
  );

  always_comb begin
    case (cond)
      COND_N:  flag_sel = flags[FLAG_N];
      COND_V:  flag_sel = flags[FLAG_V];
      COND_C:  flag_sel = flags[FLAG_C];
      default: flag_sel = flags[FLAG_Z];
    endcase
  end

  // Sign-extended add: bit 8 of the 9-bit sum is set exactly when the
  // target leaves the current page, in either direction.
  assign sum = {1'b0, pcl} + {offset[7], offset};

  always_comb begin
    state_n     = state;
    ir_n        = ir;
    onecycle_n  = onecycle;
    twocycle_n  = twocycle;
    taken_n     = taken_branch;
    cross_n     = branch_page_cross;
    offset_n    = offset;
    cond_n      = cond;
    sense_n     = sense;
    always_br_n = always_br;

    if (ready) begin
      if (t == T1) begin
        ir_n        = data_in;
        onecycle_n  = c_one;
        twocycle_n  = c_two;
        taken_n     = 1'b0;
        cross_n     = 1'b0;
        cond_n      = c_cond;
        sense_n     = c_sense;
        always_br_n = c_always;
        state_n     = c_branch ? BR_EVAL : IDLE;
      end else begin
        case (state)
          BR_EVAL: begin
            if (t == T2) begin
              offset_n = data_in;
              taken_n  = always_br || (flag_sel == sense);
              state_n  = (always_br || (flag_sel == sense)) ? BR_ADD : IDLE;
            end
          end
          BR_ADD: begin
            cross_n = sum[8];
            state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      ir                <= '0;
      onecycle          <= 1'b0;
      twocycle          <= 1'b0;
      taken_branch      <= 1'b0;
      branch_page_cross <= 1'b0;
      offset            <= '0;
      cond              <= '0;
      sense             <= 1'b0;
      always_br         <= 1'b0;
    end else begin
      state             <= state_n;
      ir                <= ir_n;
      onecycle          <= onecycle_n;
      twocycle          <= twocycle_n;
      taken_branch      <= taken_n;
      branch_page_cross <= cross_n;
      offset            <= offset_n;
      cond              <= cond_n;
      sense             <= sense_n;
      always_br         <= always_br_n;
    end
  end

endmodule

// File: tb/tb_predecode_branch.sv
// Directed self-checking bench for predecode_branch.
module tb_predecode_branch;
  import predecode_branch_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic [2:0] t;
  logic [7:0] data_in;
  logic [3:0] flags;
  logic [7:0] pcl;
  logic [7:0] ir;
  logic       onecycle, twocycle, taken_branch, branch_page_cross;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  predecode_branch dut (
    .clk               (clk),
    .reset             (reset),
    .ready             (ready),
    .t                 (t),
    .data_in           (data_in),
    .flags             (flags),
    .pcl               (pcl),
    .ir                (ir),
    .onecycle          (onecycle),
    .twocycle          (twocycle),
    .taken_branch      (taken_branch),
    .branch_page_cross (branch_page_cross)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1ns later.
  task automatic cyc(input logic [2:0] tt, input logic [7:0] d);
    t       = tt;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.state);
  endfunction

  logic [7:0] ops  [14] = '{8'hEA, 8'h1B, 8'h03, 8'hA9, 8'h68, 8'h08, 8'h18,
                             8'h8A, 8'h4A, 8'h5A, 8'hA0, 8'hE0, 8'h20, 8'hF0};
  logic [1:0] cls  [14] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01,
                             2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};

  initial begin
    reset = 1'b1; ready = 1'b1; t = T0; data_in = '0; flags = '0; pcl = '0;
    #2;
    check("rst_ir", 32'(ir), 32'h00);
    check("rst_outs", {28'd0, onecycle, twocycle, taken_branch, branch_page_cross}, 32'd0);
    check("rst_state", st(), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Classification table
    for (int unsigned i = 0; i < 14; i++) begin
      cyc(T1, ops[i]);
      check($sformatf("ir_%0h", ops[i]), 32'(ir), 32'(ops[i]));
      check($sformatf("cls_%0h", ops[i]), {30'd0, onecycle, twocycle}, 32'(cls[i]));
      cyc(T0, 8'h00);
    end
    cyc(T1, 8'hEA);
    check("ea_state", st(), 32'(IDLE));

    // BEQ taken, page cross forward
    flags = 4'b0010; pcl = 8'hF8;
    cyc(T1, 8'hF0);
    check("beq_eval", st(), 32'(BR_EVAL));
    cyc(T2, 8'h10);
    check("beq_taken", 32'(taken_branch), 32'd1);
    check("beq_st_add", st(), 32'(BR_ADD));
    cyc(T3, 8'h00);
    check("beq_cross", 32'(branch_page_cross), 32'd1);
    check("beq_idle", st(), 32'(IDLE));

    // BNE not taken
    cyc(T1, 8'hD0);
    cyc(T2, 8'h10);
    check("bne_taken", 32'(taken_branch), 32'd0);
    check("bne_idle", st(), 32'(IDLE));
    cyc(T3, 8'h00);
    check("bne_cross", 32'(branch_page_cross), 32'd0);

    // BPL backward, same page then page cross
    flags = 4'b0000; pcl = 8'h05;
    cyc(T1, 8'h10);
    cyc(T2, 8'hFE);
    check("bpl_taken", 32'(taken_branch), 32'd1);
    cyc(T3, 8'h00);
    check("bpl_nocross", 32'(branch_page_cross), 32'd0);
    pcl = 8'h01;
    cyc(T1, 8'h10);
    cyc(T2, 8'hFE);
    cyc(T3, 8'h00);
    check("bpl_cross", 32'(branch_page_cross), 32'd1);
    cyc(T1, 8'hEA);
    check("t1_clr", {30'd0, taken_branch, branch_page_cross}, 32'd0);

    // ready low while in BR_ADD
    flags = 4'b0010; pcl = 8'hF8;
    cyc(T1, 8'hF0);
    cyc(T2, 8'h10);
    ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(T1, 8'hEA);
      check("hold_state", st(), 32'(BR_ADD));
      check("hold_ir", 32'(ir), 32'hF0);
      check("hold_outs", {30'd0, taken_branch, branch_page_cross}, 32'b10);
    end
    ready = 1'b1;
    cyc(T3, 8'h00);
    check("hold_cross", 32'(branch_page_cross), 32'd1);
    check("hold_idle", st(), 32'(IDLE));

    // New opcode in T1 aborts a pending branch
    cyc(T1, 8'hF0);
    cyc(T1, 8'hEA);
    check("abort_state", st(), 32'(IDLE));
    check("abort_ir", 32'(ir), 32'hEA);

    // Async reset in BR_EVAL
    cyc(T1, 8'hF0);
    check("pre_rst_eval", st(), 32'(BR_EVAL));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ir", 32'(ir), 32'h00);
    check("mid_rst_outs", {28'd0, onecycle, twocycle, taken_branch, branch_page_cross}, 32'd0);
    check("mid_rst_state", st(), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    cyc(T2, 8'h10);
    check("post_rst_t2", {30'd0, taken_branch, st() == 32'(IDLE)}, 32'b01);

    // Opcode 8'h80
    flags = 4'b0000; pcl = 8'h10;
    cyc(T1, 8'h80);
`ifdef CMOS_BRA_EN
    check("bra_two", 32'(twocycle), 32'd0);
    check("bra_state", st(), 32'(BR_EVAL));
    cyc(T2, 8'h02);
    check("bra_taken", 32'(taken_branch), 32'd1);
    check("bra_add", st(), 32'(BR_ADD));
`else
    check("op80_two", 32'(twocycle), 32'd1);
    check("op80_state", st(), 32'(IDLE));
    cyc(T2, 8'h02);
    check("op80_taken", 32'(taken_branch), 32'd0);
    check("op80_idle", st(), 32'(IDLE));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
